ps2_kbd_ctrl: RTL and testbench

Sequencing controller for the `ps2_keyboard` receiver. It drains bytes from the receiver's internal FIFO using the `ready` / `nextdata_n` handshake. It parses PS/2 set-2 scan-code prefixes (E0 extended, F0 break) into complete key events, optionally filters typematic auto-repeat, and buffers events in a small queue with a valid/ready interface toward the consumer (display / CPU glue). It replaces the ad-hoc pop logic in the keyboard top level.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/kbd_evq.sv | 70 +++++++
 rtl/ps2_kbd_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants, FSM encodings and the key-event payload.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        P_BASE,
        P_E0,
        P_F0,
        P_E0F0
    } parse_state_e;

    typedef enum logic {
        POP_IDLE,
        POP_STROBE
    } pop_state_e;

    // 'release' is a reserved word, so the break flag is named rel.
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } kbd_event_t;

endpackage

// File: rtl/kbd_evq.sv
// Key-event FIFO: circular buffer with an extra pointer bit for full/empty;
// the head is read straight out of the registered storage.
module kbd_evq
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       push,
    input  logic       pop,
    input  kbd_event_t din,
    output logic       full,
    output logic       empty,
    output kbd_event_t head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    kbd_event_t     mem_q [DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           full_q, full_d;
    logic           empty_q, empty_d;
    logic           wr_en_c;
    logic           rd_en_c;

    always_comb begin
        wr_en_c  = push && (!full_q || pop);
        rd_en_c  = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
        end
        if (rd_en_c) begin
            rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d == {~rd_ptr_d[PTR_W], rd_ptr_d[PTR_W-1:0]});
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is reset so the head reads as all-zero out of reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mem_q <= '{default: '0};
        end else if (wr_en_c) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencer: pops bytes from the receiver, assembles E0/F0
// prefixed scan codes into key events, filters auto-repeat and queues events.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned EVQ_DEPTH     = 4,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned FILTER_REPEAT = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    input  logic             kb_overflow,
    output logic             kb_nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_release,
    output logic [CNT_W-1:0] press_cnt,
    output logic [1:0]       err_sticky,
    input  logic             err_clr
);

    pop_state_e       pop_q, pop_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_vld_q, byte_vld_d;
    parse_state_e     parse_q, parse_d, parse_eff;
    logic             held_vld_q, held_vld_d;
    logic             held_ext_q, held_ext_d;
    logic [7:0]       held_code_q, held_code_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [1:0]       err_q, err_d;
    kbd_event_t       ev_c;
    kbd_event_t       head;
    logic             ev_vld_c, held_match_c, push_c, pop_c, accept_c, drop_c;
    logic             q_full, q_empty;

    // Pop handshake: latch on ready, then one strobe cycle so no byte is popped twice.
    always_comb begin
        pop_d        = pop_q;
        byte_d       = byte_q;
        byte_vld_d   = 1'b0;
        nextdata_n_d = 1'b1;
        case (pop_q)
            POP_IDLE: begin
                if (kb_ready) begin
                    pop_d        = POP_STROBE;
                    byte_d       = kb_data;
                    byte_vld_d   = 1'b1;
                    nextdata_n_d = 1'b0;
                end
            end
            POP_STROBE: pop_d = POP_IDLE;
            default:    pop_d = POP_IDLE;
        endcase
    end

    // Prefix parser; an illegal prefix order drops the pending prefixes first.
    always_comb begin
        parse_d   = parse_q;
        parse_eff = parse_q;
        ev_vld_c  = 1'b0;
        ev_c      = '0;
        if (byte_vld_q) begin
            if ((byte_q == PS2_PFX_EXT && (parse_q == P_F0 || parse_q == P_E0F0)) ||
                (byte_q == PS2_PFX_BRK && parse_q == P_E0F0)) begin
                parse_eff = P_BASE;
            end
            ev_c.ext  = (parse_eff == P_E0) || (parse_eff == P_E0F0);
            ev_c.rel  = (parse_eff == P_F0) || (parse_eff == P_E0F0);
            ev_c.code = byte_q;
            if (byte_q == PS2_PFX_EXT) begin
                parse_d = P_E0;
            end else if (byte_q == PS2_PFX_BRK) begin
                parse_d = (parse_eff == P_E0) ? P_E0F0 : P_F0;
            end else begin
                ev_vld_c = 1'b1;
                parse_d  = P_BASE;
            end
        end
    end

    // Repeat filter, queue admission, press counter and sticky errors.
    always_comb begin
        held_vld_d   = held_vld_q;
        held_ext_d   = held_ext_q;
        held_code_d  = held_code_q;
        held_match_c = held_vld_q && (held_ext_q == ev_c.ext) && (held_code_q == ev_c.code);
        push_c       = ev_vld_c;
        if (ev_vld_c && FILTER_REPEAT != 0) begin
            if (!ev_c.rel) begin
                if (held_match_c) begin
                    push_c = 1'b0;
                end else begin
                    held_vld_d  = 1'b1;
                    held_ext_d  = ev_c.ext;
                    held_code_d = ev_c.code;
                end
            end else if (held_match_c) begin
                held_vld_d = 1'b0;
            end
        end
        pop_c       = !q_empty && ev_ready;
        accept_c    = push_c && (!q_full || pop_c);
        drop_c      = push_c && !accept_c;
        press_cnt_d = press_cnt_q + CNT_W'(accept_c && !ev_c.rel);
        err_d       = err_clr ? 2'b00 : err_q;
        err_d[0]    = err_d[0] | kb_overflow;
        err_d[1]    = err_d[1] | drop_c;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pop_q        <= POP_IDLE;
            nextdata_n_q <= 1'b1;
            byte_q       <= '0;
            byte_vld_q   <= 1'b0;
            parse_q      <= P_BASE;
            held_vld_q   <= 1'b0;
            held_ext_q   <= 1'b0;
            held_code_q  <= '0;
            press_cnt_q  <= '0;
            err_q        <= '0;
        end else begin
            pop_q        <= pop_d;
            nextdata_n_q <= nextdata_n_d;
            byte_q       <= byte_d;
            byte_vld_q   <= byte_vld_d;
            parse_q      <= parse_d;
            held_vld_q   <= held_vld_d;
            held_ext_q   <= held_ext_d;
            held_code_q  <= held_code_d;
            press_cnt_q  <= press_cnt_d;
            err_q        <= err_d;
        end
    end

    kbd_evq #(
        .DEPTH (EVQ_DEPTH)
    ) u_evq (
        .clk   (clk),
        .clrn  (clrn),
        .push  (accept_c),
        .pop   (pop_c),
        .din   (ev_c),
        .full  (q_full),
        .empty (q_empty),
        .head  (head)
    );

    assign kb_nextdata_n = nextdata_n_q;
    assign ev_valid      = !q_empty;
    assign ev_code       = head.code;
    assign ev_ext        = head.ext;
    assign ev_release    = head.rel;
    assign press_cnt     = press_cnt_q;
    assign err_sticky    = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: a receiver FIFO model feeds bytes, an event-level
// model predicts the queue, counter and error flags, checked every cycle.
module tb_ps2_kbd_ctrl;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_overflow = 1'b0;
    logic       kb_nextdata_n;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_release;
    logic [7:0] press_cnt;
    logic [1:0] err_sticky;
    logic       err_clr = 1'b0;

    ps2_kbd_ctrl #(
        .EVQ_DEPTH     (DEPTH),
        .CNT_W         (8),
        .FILTER_REPEAT (1)
    ) dut (
        .clk           (clk),
        .clrn          (clrn),
        .kb_data       (kb_data),
        .kb_ready      (kb_ready),
        .kb_overflow   (kb_overflow),
        .kb_nextdata_n (kb_nextdata_n),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_code       (ev_code),
        .ev_ext        (ev_ext),
        .ev_release    (ev_release),
        .press_cnt     (press_cnt),
        .err_sticky    (err_sticky),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    logic [7:0] rxq [$];
    logic [9:0] mq  [$];
    logic [9:0] got [$];
    logic [9:0] exp_q [$];
    bit         m_ext = 1'b0, m_brk = 1'b0, h_vld = 1'b0;
    logic [8:0] h_key = '0;
    logic [7:0] m_cnt = '0;
    logic [1:0] m_err = '0;
    int         n_cmp = 0, n_bad = 0;
    int         low_cycles = 0;
    bit         prev_low = 1'b0;
    bit         chk_en = 1'b0;

    function automatic logic [9:0] ev(input bit e, input bit r, input logic [7:0] c);
        return {e, r, c};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Event-level model: receiver FIFO pops on the strobe, prefixes tracked as flags.
    always @(posedge clk or negedge clrn) begin
        logic [7:0] b;
        logic [9:0] e;
        bit         push, pop_now, drop;
        if (!clrn) begin
            rxq.delete();
            mq.delete();
            m_ext = 0; m_brk = 0; h_vld = 0; h_key = '0; m_cnt = '0; m_err = '0;
        end else begin
            pop_now = ev_ready && (mq.size() != 0);
            if (pop_now) got.push_back({ev_ext, ev_release, ev_code});
            push = 0;
            drop = 0;
            e    = '0;
            if (!kb_nextdata_n) begin
                if (rxq.size() == 0) begin
                    check("pop_underflow", 1, 0);
                end else begin
                    b = rxq.pop_front();
                    if ((b == 8'hE0 && m_brk) || (b == 8'hF0 && m_ext && m_brk)) begin
                        m_ext = 0; m_brk = 0;
                    end
                    if (b == 8'hE0) m_ext = 1;
                    else if (b == 8'hF0) m_brk = 1;
                    else begin
                        e = {m_ext, m_brk, b};
                        m_ext = 0; m_brk = 0;
                        push = 1;
                        if (!e[8]) begin
                            if (h_vld && h_key == {e[9], e[7:0]}) push = 0;
                            else begin h_vld = 1; h_key = {e[9], e[7:0]}; end
                        end else if (h_vld && h_key == {e[9], e[7:0]}) begin
                            h_vld = 0;
                        end
                    end
                end
            end
            if (push && mq.size() >= DEPTH && !pop_now) begin
                drop = 1;
                push = 0;
            end
            if (push && !e[8]) m_cnt = m_cnt + 8'd1;
            if (err_clr) m_err = 2'b00;
            if (kb_overflow) m_err[0] = 1'b1;
            if (drop) m_err[1] = 1'b1;
            if (pop_now) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
    end

    // Receiver outputs follow the model FIFO, updated away from the active edge.
    always @(negedge clk) begin
        kb_ready = (rxq.size() != 0);
        kb_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    always @(negedge clk) begin
        if (clrn && chk_en) begin
            check("ev_valid", ev_valid, mq.size() != 0);
            if (mq.size() != 0) check("ev_head", {ev_ext, ev_release, ev_code}, mq[0]);
            check("press_cnt", press_cnt, m_cnt);
            check("err_sticky", err_sticky, m_err);
            if (!kb_nextdata_n) begin
                low_cycles++;
                check("strobe_single", prev_low, 0);
            end
            prev_low = !kb_nextdata_n;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        chk_en = 0;
        clrn = 0;
        tick(2);
        clrn = 1;
        got.delete();
        low_cycles = 0;
        prev_low = 0;
        tick(1);
        chk_en = 1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (rxq.size() == 0) break;
            tick(1);
        end
        check("drained", rxq.size(), 0);
        tick(4);
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check(name, got[i], exp_q[i]);
    endtask

    task automatic wait_strobe();
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!kb_nextdata_n) break;
        end
        check("strobe_seen", kb_nextdata_n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_nextdata_n", kb_nextdata_n, 1);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_code", ev_code, 0);
        check("rst_ev_ext", ev_ext, 0);
        check("rst_ev_release", ev_release, 0);
        check("rst_press_cnt", press_cnt, 0);
        check("rst_err_sticky", err_sticky, 0);

        // Single make code
        ev_ready = 1;
        rxq.push_back(8'h1C);
        drain();
        exp_q = {ev(0, 0, 8'h1C)};
        check_log("t1_log");
        check("t1_press", press_cnt, 1);
        check("t1_strobe_cycles", low_cycles, 1);

        // Extended break
        got.delete();
        rxq.push_back(8'hE0); rxq.push_back(8'hF0); rxq.push_back(8'h75);
        drain();
        exp_q = {ev(1, 1, 8'h75)};
        check_log("t2_log");
        check("t2_press", press_cnt, 1);

        // Auto-repeat filtering
        do_reset();
        ev_ready = 1;
        rxq.push_back(8'h1C); rxq.push_back(8'h1C); rxq.push_back(8'h1C);
        rxq.push_back(8'hF0); rxq.push_back(8'h1C);
        drain();
        exp_q = {ev(0, 0, 8'h1C), ev(0, 1, 8'h1C)};
        check_log("t3_log");
        check("t3_press", press_cnt, 1);

        // Queue overflow with a stalled consumer
        do_reset();
        ev_ready = 0;
        rxq.push_back(8'h15); rxq.push_back(8'h1D); rxq.push_back(8'h24);
        rxq.push_back(8'h2D); rxq.push_back(8'h2C);
        drain();
        check("t4_press", press_cnt, 4);
        check("t4_err", err_sticky, 2'b10);
        check("t4_head", ev_code, 8'h15);
        err_clr = 1; tick(1); err_clr = 0; tick(1);
        check("t4_err_clr", err_sticky, 2'b00);
        ev_ready = 1; tick(6); ev_ready = 0;
        exp_q = {ev(0, 0, 8'h15), ev(0, 0, 8'h1D), ev(0, 0, 8'h24), ev(0, 0, 8'h2D)};
        check_log("t4_log");

        // Full queue, pop and push on the same edge
        do_reset();
        ev_ready = 0;
        rxq.push_back(8'h15); rxq.push_back(8'h1D); rxq.push_back(8'h24); rxq.push_back(8'h2D);
        drain();
        rxq.push_back(8'h2C);
        wait_strobe();
        ev_ready = 1; tick(1); ev_ready = 0;
        tick(1);
        check("t5_err", err_sticky, 2'b00);
        check("t5_press", press_cnt, 5);
        check("t5_head", ev_code, 8'h1D);
        ev_ready = 1; tick(6); ev_ready = 0;
        exp_q = {ev(0, 0, 8'h15), ev(0, 0, 8'h1D), ev(0, 0, 8'h24), ev(0, 0, 8'h2D), ev(0, 0, 8'h2C)};
        check_log("t5_log");

        // Bad prefix order: F0 discarded by the following E0
        do_reset();
        ev_ready = 1;
        rxq.push_back(8'hF0); rxq.push_back(8'hE0); rxq.push_back(8'h1C);
        drain();
        exp_q = {ev(1, 0, 8'h1C)};
        check_log("t6_log");
        check("t6_press", press_cnt, 1);

        // Receiver overflow, then set beating clear in the same cycle
        kb_overflow = 1; tick(1); kb_overflow = 0; tick(1);
        check("t7_ovf", err_sticky, 2'b01);
        err_clr = 1; kb_overflow = 1; tick(1); err_clr = 0; kb_overflow = 0; tick(1);
        check("t7_set_wins", err_sticky, 2'b01);

        // Asynchronous reset during the pop strobe
        ev_ready = 0;
        rxq.push_back(8'h2C);
        wait_strobe();
        chk_en = 0;
        #1 clrn = 0;
        #1;
        check("t8_nextdata_n", kb_nextdata_n, 1);
        check("t8_ev_valid", ev_valid, 0);
        check("t8_ev_code", ev_code, 0);
        check("t8_press", press_cnt, 0);
        check("t8_err", err_sticky, 0);
        tick(2);
        clrn = 1;
        tick(1);
        chk_en = 1;
        tick(5);
        check("t8_byte_lost", ev_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
